// File: rtl/mux8_arbiter_pkg.sv
// Shared types and helpers for the mux8_arbiter round-robin sequencer.
package mux8_arbiter_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mux8_arb_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // First set request scanning ptr, ptr+1, ... with 3-bit wrap.
  function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                       input logic [SEL_W-1:0]   ptr);
    rr_pick_t         r;
    logic [SEL_W-1:0] idx;
    r = '0;
    // Walk from the farthest offset back so the nearest hit wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multiplexer8.sv
// Eight-way data multiplexer; y is the WIDTH-bit slice of data selected by sel.
module multiplexer8 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]         sel,
  input  logic [8*WIDTH-1:0] data,
  output logic [WIDTH-1:0]   y
);

  always_comb begin
    y = data[32'(sel) * WIDTH +: WIDTH];
  end

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter driving a multiplexer8 onto one valid/ready channel.
// Define MUX8_ARBITER_LOCK_EN to hold ownership until a req_last beat is accepted.
module mux8_arbiter
  import mux8_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [7:0]           req,
  input  logic [7:0]           req_last,
  input  logic [8*WIDTH-1:0]   req_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [2:0]           out_src,
  output logic [7:0]           grant
);

  mux8_arb_state_e  state, state_d;
  logic [SEL_W-1:0] ptr, ptr_d;
  logic [SEL_W-1:0] sel, sel_d;
  rr_pick_t         pick;
  logic             end_of_burst;

`ifdef MUX8_ARBITER_LOCK_EN
  assign end_of_burst = req_last[sel];
`else
  // Every accepted beat releases ownership; req_last has no effect.
  logic unused_req_last;
  assign unused_req_last = ^req_last;
  assign end_of_burst    = 1'b1;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      sel   <= sel_d;
    end
  end

  // Next-state and channel outputs.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    sel_d     = sel;
    out_valid = 1'b0;
    grant     = '0;
    pick      = rr_pick(req, ptr);
    unique case (state)
      IDLE: begin
        if (pick.found) begin
          sel_d   = pick.idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        out_valid = req[sel];
        if (!req[sel]) begin
          ptr_d   = sel + SEL_W'(1);
          state_d = IDLE;
        end else if (out_ready) begin
          grant[sel] = 1'b1;
          if (end_of_burst) begin
            ptr_d   = sel + SEL_W'(1);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_src = sel;

  multiplexer8 #(.WIDTH(WIDTH)) u_mux (
    .sel  (sel),
    .data (req_data),
    .y    (out_data)
  );

endmodule

// File: tb/tb_mux8_arbiter.sv
// Self-checking bench for mux8_arbiter: vector table plus directed corner sequences.
module tb_mux8_arbiter;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_src;
    logic [7:0] exp_grant;
  } vec_t;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [7:0]         req;
  logic [7:0]         req_last;
  logic [8*WIDTH-1:0] req_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_src;
  logic [7:0]         grant;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t tbl [18];

  mux8_arbiter #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_last  (req_last),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .grant     (grant)
  );

  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] slice_val(input int i);
    return 32'h1000_0000 * 32'(i + 1) + 32'(i * 32'h0101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance.
  task automatic beat(input string name, input logic [7:0] r, input logic rdy,
                      input logic [7:0] rl, input logic ev, input logic [2:0] es,
                      input logic [7:0] eg);
    req       = r;
    out_ready = rdy;
    req_last  = rl;
    #1;
    chk({name, ".valid"}, 32'(out_valid), 32'(ev));
    chk({name, ".grant"}, 32'(grant), 32'(eg));
    if (ev) begin
      chk({name, ".src"},  32'(out_src), 32'(es));
      chk({name, ".data"}, out_data, slice_val(int'(es)));
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) req_data[i*WIDTH +: WIDTH] = slice_val(i);
    // Round robin with all requesters active: grants 0..7,0 every other cycle.
    for (int k = 0; k < 9; k++) begin
      tbl[2*k]   = '{req: 8'hFF, ready: 1'b1, exp_valid: 1'b0,
                     exp_src: 3'(k % 8), exp_grant: 8'h00};
      tbl[2*k+1] = '{req: 8'hFF, ready: 1'b1, exp_valid: 1'b1,
                     exp_src: 3'(k % 8), exp_grant: 8'(1 << (k % 8))};
    end

    // Reset held with everybody requesting.
    reset_n   = 1'b0;
    req       = 8'hFF;
    req_last  = 8'h00;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.src",   32'(out_src), 32'd0);
    chk("rst.data",  out_data, slice_val(0));
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++)
      beat($sformatf("rr%0d", i), tbl[i].req, tbl[i].ready, 8'h00,
           tbl[i].exp_valid, tbl[i].exp_src, tbl[i].exp_grant);

    // Move ptr to 3 by granting requester 2, then wrap/skip over 8'b1000_0100.
    beat("pre.idle", 8'h04, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
    beat("pre.busy", 8'h04, 1'b1, 8'h00, 1'b1, 3'd2, 8'h04);
    beat("wrap.i0",  8'h84, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
    beat("wrap.b0",  8'h84, 1'b1, 8'h00, 1'b1, 3'd7, 8'h80);
    beat("wrap.i1",  8'h84, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
    beat("wrap.b1",  8'h84, 1'b1, 8'h00, 1'b1, 3'd2, 8'h04);
    beat("wrap.i2",  8'h84, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
    beat("wrap.b2",  8'h84, 1'b1, 8'h00, 1'b1, 3'd7, 8'h80);

    // Backpressure: five stalled cycles then a single grant pulse.
    beat("bp.idle", 8'h08, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 5; i++)
      beat($sformatf("bp.hold%0d", i), 8'h08, 1'b0, 8'h00, 1'b1, 3'd3, 8'h00);
    beat("bp.acc",  8'h08, 1'b1, 8'h00, 1'b1, 3'd3, 8'h08);
    beat("bp.post", 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);

    // Withdrawal: requester 4 drops before accept; next pick starts at 5.
    beat("wd.idle", 8'h10, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    beat("wd.busy", 8'h10, 1'b0, 8'h00, 1'b1, 3'd4, 8'h00);
    beat("wd.drop", 8'h21, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
    chk("wd.src_hold", 32'(out_src), 32'd4);
    beat("wd.idle2", 8'h21, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
    beat("wd.next",  8'h21, 1'b1, 8'h00, 1'b1, 3'd5, 8'h20);

    // Burst from requester 1 while requester 2 also waits (ptr is 6).
    beat("lk.idle", 8'h06, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
`ifdef MUX8_ARBITER_LOCK_EN
    beat("lk.b1",   8'h06, 1'b1, 8'h00, 1'b1, 3'd1, 8'h02);
    beat("lk.b2",   8'h06, 1'b1, 8'h00, 1'b1, 3'd1, 8'h02);
    beat("lk.b3",   8'h06, 1'b1, 8'h02, 1'b1, 3'd1, 8'h02);
    beat("lk.idle2", 8'h04, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
    beat("lk.next", 8'h04, 1'b1, 8'h00, 1'b1, 3'd2, 8'h04);
`else
    beat("nl.b1",    8'h06, 1'b1, 8'h00, 1'b1, 3'd1, 8'h02);
    beat("nl.idle2", 8'h06, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
    beat("nl.next",  8'h06, 1'b1, 8'h00, 1'b1, 3'd2, 8'h04);
`endif

    // Reset mid-transfer drops the beat; arbitration restarts from ptr 0.
    beat("mr.idle", 8'h10, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    req = 8'h10;
    #1;
    chk("mr.busy.valid", 32'(out_valid), 32'd1);
    chk("mr.busy.src",   32'(out_src), 32'd4);
    reset_n = 1'b0;
    #1;
    chk("mr.rst.valid", 32'(out_valid), 32'd0);
    chk("mr.rst.grant", 32'(grant), 32'd0);
    chk("mr.rst.src",   32'(out_src), 32'd0);
    tick();
    reset_n = 1'b1;
    beat("mr.idle2", 8'h81, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
    beat("mr.first", 8'h81, 1'b1, 8'h00, 1'b1, 3'd0, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
